// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency-sweep logic.
//   - default frequency-word and dwell-counter widths
//   - sweep FSM state encoding
//   - next_word(): one up/down frequency step, clamped to the stop word
package dds_pkg;

    localparam int FW_W_DEF = 32;
    localparam int DW_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

    // The up step is evaluated one bit wider so that a carry out of the word
    // clamps to the stop value instead of wrapping to a low frequency.
    // A zero step jumps straight to the stop value so a sweep always ends.
    function automatic logic [FW_W_DEF-1:0] next_word(
        input logic [FW_W_DEF-1:0] cur,
        input logic [FW_W_DEF-1:0] step,
        input logic [FW_W_DEF-1:0] stop,
        input logic                up
    );
        logic [FW_W_DEF:0]   sum;
        logic [FW_W_DEF-1:0] nxt;
        sum = {1'b0, cur} + {1'b0, step};
        if (step == '0)
            nxt = stop;
        else if (up)
            nxt = (sum[FW_W_DEF] || (sum[FW_W_DEF-1:0] > stop)) ? stop : sum[FW_W_DEF-1:0];
        else
            nxt = ((cur < step) || ((cur - step) < stop)) ? stop : (cur - step);
        return nxt;
    endfunction

endpackage

// File: rtl/dds_sweep_if.sv
// Control/status bundle between a sweep requester and dds_sweep_ctrl.
//   master : drives Start/Abort/Continuous and the sweep parameters,
//            observes Fword/Busy/Done
//   slave  : the sweep controller
interface dds_sweep_if #(
    parameter int FW_W = dds_pkg::FW_W_DEF,
    parameter int DW_W = dds_pkg::DW_W_DEF
);
    logic            Start;
    logic            Abort;
    logic            Continuous;
    logic [FW_W-1:0] Start_Fword;
    logic [FW_W-1:0] Stop_Fword;
    logic [FW_W-1:0] Step_Fword;
    logic [DW_W-1:0] Dwell;
    logic [FW_W-1:0] Fword;
    logic            Busy;
    logic            Done;

    modport master (
        output Start, Abort, Continuous, Start_Fword, Stop_Fword, Step_Fword, Dwell,
        input  Fword, Busy, Done
    );

    modport slave (
        input  Start, Abort, Continuous, Start_Fword, Stop_Fword, Step_Fword, Dwell,
        output Fword, Busy, Done
    );
endinterface

// File: rtl/sweep_dwell_cnt.sv
// Loadable down-counter timing how long each frequency word is held.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val (has priority over en)
//   load_val  : value loaded; the word is held load_val+1 cycles
//   en        : decrement while non-zero
//   expired   : count is zero (terminal count)
module sweep_dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (en && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign expired = (count_q == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller feeding the DDS phase accumulator.
// Steps Fword from a start to a stop word, holding each value for a dwell
// period, in single-shot or continuous mode, with abort.
//   Clk, Reset : system clock, async active-high reset
//   sw         : slave side of dds_sweep_if (controls in, Fword/Busy/Done out)
//
//   state | meaning
//   IDLE  | waiting for Start; Fword holds its last value
//   DWELL | holding Fword; on counter expiry the next word is applied
//   DONE  | one-cycle Done pulse after a single sweep
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW_W = FW_W_DEF,
    parameter int DW_W = DW_W_DEF
) (
    input  logic     Clk,
    input  logic     Reset,
    dds_sweep_if.slave sw
);
    sweep_state_e    state_q, state_d;
    logic [FW_W-1:0] fword_q, fword_d;
    logic [FW_W-1:0] start_l_q, start_l_d;
    logic [FW_W-1:0] stop_l_q, stop_l_d;
    logic [FW_W-1:0] step_l_q, step_l_d;
    logic [DW_W-1:0] reload_q, reload_d;
    logic            cont_l_q, cont_l_d;
    logic            dir_up_q, dir_up_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            cnt_load;
    logic [DW_W-1:0] cnt_load_val;
    logic            cnt_en;
    logic            cnt_expired;

    sweep_dwell_cnt #(.W(DW_W)) u_dwell_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .expired  (cnt_expired)
    );

    always_comb begin
        state_d      = state_q;
        fword_d      = fword_q;
        start_l_d    = start_l_q;
        stop_l_d     = stop_l_q;
        step_l_d     = step_l_q;
        reload_d     = reload_q;
        cont_l_d     = cont_l_q;
        dir_up_d     = dir_up_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = reload_q;
        cnt_en       = 1'b0;

        case (state_q)
            // DONE accepts Start too, so a new sweep can begin the cycle
            // after the Done pulse is sampled.
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (sw.Start && !sw.Abort) begin
                    start_l_d    = sw.Start_Fword;
                    stop_l_d     = sw.Stop_Fword;
                    step_l_d     = sw.Step_Fword;
                    cont_l_d     = sw.Continuous;
                    dir_up_d     = (sw.Start_Fword <= sw.Stop_Fword);
                    reload_d     = (sw.Dwell == '0) ? '0 : (sw.Dwell - 1'b1);
                    fword_d      = sw.Start_Fword;
                    busy_d       = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = reload_d;
                    state_d      = DWELL;
                end
            end
            DWELL: begin
                if (sw.Abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_expired) begin
                    if (fword_q == stop_l_q) begin
                        if (cont_l_q) begin
                            fword_d  = start_l_q;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        fword_d  = next_word(fword_q, step_l_q, stop_l_q, dir_up_q);
                        cnt_load = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            fword_q   <= '0;
            start_l_q <= '0;
            stop_l_q  <= '0;
            step_l_q  <= '0;
            reload_q  <= '0;
            cont_l_q  <= 1'b0;
            dir_up_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fword_q   <= fword_d;
            start_l_q <= start_l_d;
            stop_l_q  <= stop_l_d;
            step_l_q  <= step_l_d;
            reload_q  <= reload_d;
            cont_l_q  <= cont_l_d;
            dir_up_q  <= dir_up_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sw.Fword = fword_q;
    assign sw.Busy  = busy_q;
    assign sw.Done  = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dds_sweep_if #(.FW_W(32), .DW_W(16)) sw ();

    dds_sweep_ctrl #(.FW_W(32), .DW_W(16)) dut (
        .Clk   (clk),
        .Reset (rst),
        .sw    (sw)
    );

    // Called at a negedge; returns at the negedge right after the Start edge.
    task automatic kick(input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                        input logic [15:0] d, input logic c);
        sw.Start_Fword = s;
        sw.Stop_Fword  = p;
        sw.Step_Fword  = st;
        sw.Dwell       = d;
        sw.Continuous  = c;
        sw.Abort       = 1'b0;
        sw.Start       = 1'b1;
        @(negedge clk);
        sw.Start       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw.Start = 0; sw.Abort = 0; sw.Continuous = 0;
        sw.Start_Fword = 0; sw.Stop_Fword = 0; sw.Step_Fword = 0; sw.Dwell = 0;
        @(negedge clk);
        n_cmp++; if (sw.Fword !== 32'd0) begin n_err++; $display("FAIL reset_fword: got %0h, required 0", sw.Fword); end
        n_cmp++; if (sw.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", sw.Busy); end
        n_cmp++; if (sw.Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", sw.Done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_up_single();
        logic [31:0] exp_w [4] = '{32'd100, 32'd200, 32'd300, 32'd400};
        kick(100, 400, 100, 3, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (sw.Fword !== exp_w[i] || sw.Busy !== 1'b1 || sw.Done !== 1'b0) begin
                    n_err++;
                    $display("FAIL up_single v%0d c%0d: Fword=%0d Busy=%b Done=%b, required Fword=%0d Busy=1 Done=0",
                             i, j, sw.Fword, sw.Busy, sw.Done, exp_w[i]);
                end
                @(negedge clk);
            end
        n_cmp++;
        if (sw.Done !== 1'b1 || sw.Busy !== 1'b0 || sw.Fword !== 32'd400) begin
            n_err++; $display("FAIL up_single_done: Done=%b Busy=%b Fword=%0d, required 1 0 400", sw.Done, sw.Busy, sw.Fword);
        end
        @(negedge clk);
        n_cmp++; if (sw.Done !== 1'b0) begin n_err++; $display("FAIL up_single_done_pulse: Done=%b, required 0", sw.Done); end
    endtask

    task automatic test_clamp();
        logic [31:0] exp_a [4] = '{32'd0, 32'd100, 32'd200, 32'd250};
        logic [31:0] exp_b [3] = '{32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFFFF};
        kick(0, 250, 100, 1, 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (sw.Fword !== exp_a[i] || sw.Busy !== 1'b1) begin
                n_err++; $display("FAIL clamp_a v%0d: Fword=%0d Busy=%b, required %0d 1", i, sw.Fword, sw.Busy, exp_a[i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (sw.Done !== 1'b1 || sw.Fword !== 32'd250) begin
            n_err++; $display("FAIL clamp_a_done: Done=%b Fword=%0d, required 1 250", sw.Done, sw.Fword);
        end
        @(negedge clk);
        kick(32'hFFFFFF00, 32'hFFFFFFFF, 32'h80, 1, 0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sw.Fword !== exp_b[i] || sw.Busy !== 1'b1) begin
                n_err++; $display("FAIL clamp_ovf v%0d: Fword=%0h Busy=%b, required %0h 1", i, sw.Fword, sw.Busy, exp_b[i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (sw.Done !== 1'b1 || sw.Fword !== 32'hFFFFFFFF) begin
            n_err++; $display("FAIL clamp_ovf_done: Done=%b Fword=%0h, required 1 ffffffff", sw.Done, sw.Fword);
        end
        @(negedge clk);
    endtask

    task automatic test_down_dwell0();
        logic [31:0] exp_w [4] = '{32'd500, 32'd350, 32'd200, 32'd100};
        kick(500, 100, 150, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (sw.Fword !== exp_w[i] || sw.Busy !== 1'b1 || sw.Done !== 1'b0) begin
                n_err++; $display("FAIL down v%0d: Fword=%0d Busy=%b Done=%b, required %0d 1 0", i, sw.Fword, sw.Busy, sw.Done, exp_w[i]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (sw.Done !== 1'b1 || sw.Busy !== 1'b0 || sw.Fword !== 32'd100) begin
            n_err++; $display("FAIL down_done: Done=%b Busy=%b Fword=%0d, required 1 0 100", sw.Done, sw.Busy, sw.Fword);
        end
        @(negedge clk);
    endtask

    task automatic test_continuous_abort();
        logic [31:0] seq [10] = '{32'd10, 32'd10, 32'd20, 32'd20, 32'd30, 32'd30, 32'd10, 32'd10, 32'd20, 32'd20};
        kick(10, 30, 10, 2, 1);
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (sw.Fword !== seq[c] || sw.Busy !== 1'b1 || sw.Done !== 1'b0) begin
                n_err++; $display("FAIL cont c%0d: Fword=%0d Busy=%b Done=%b, required %0d 1 0", c, sw.Fword, sw.Busy, sw.Done, seq[c]);
            end
            if (c == 9) sw.Abort = 1'b1;
            @(negedge clk);
        end
        sw.Abort = 1'b0;
        n_cmp++;
        if (sw.Busy !== 1'b0 || sw.Fword !== 32'd20 || sw.Done !== 1'b0) begin
            n_err++; $display("FAIL abort: Busy=%b Fword=%0d Done=%b, required 0 20 0", sw.Busy, sw.Fword, sw.Done);
        end
        @(negedge clk);
        n_cmp++;
        if (sw.Busy !== 1'b0 || sw.Fword !== 32'd20 || sw.Done !== 1'b0) begin
            n_err++; $display("FAIL abort_hold: Busy=%b Fword=%0d Done=%b, required 0 20 0", sw.Busy, sw.Fword, sw.Done);
        end
    endtask

    task automatic test_abort_start_same();
        sw.Start_Fword = 1000; sw.Stop_Fword = 2000; sw.Step_Fword = 10; sw.Dwell = 1; sw.Continuous = 0;
        sw.Start = 1'b1; sw.Abort = 1'b1;
        @(negedge clk);
        sw.Start = 1'b0; sw.Abort = 1'b0;
        n_cmp++;
        if (sw.Busy !== 1'b0 || sw.Fword !== 32'd20) begin
            n_err++; $display("FAIL abort_start_same: Busy=%b Fword=%0d, required 0 20", sw.Busy, sw.Fword);
        end
        @(negedge clk);
        n_cmp++; if (sw.Busy !== 1'b0) begin n_err++; $display("FAIL abort_start_same_later: Busy=%b, required 0", sw.Busy); end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] exp_w [4] = '{32'd1000, 32'd1100, 32'd1200, 32'd1300};
        int c = 0;
        kick(1000, 1300, 100, 2, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if (sw.Fword !== exp_w[i] || sw.Busy !== 1'b1) begin
                    n_err++; $display("FAIL busy_start v%0d c%0d: Fword=%0d Busy=%b, required %0d 1", i, j, sw.Fword, sw.Busy, exp_w[i]);
                end
                if (c == 3) begin
                    sw.Start_Fword = 5; sw.Stop_Fword = 7; sw.Step_Fword = 1; sw.Dwell = 9; sw.Continuous = 1;
                    sw.Start = 1'b1;
                end else begin
                    sw.Start = 1'b0;
                end
                c++;
                @(negedge clk);
            end
        n_cmp++;
        if (sw.Done !== 1'b1 || sw.Busy !== 1'b0 || sw.Fword !== 32'd1300) begin
            n_err++; $display("FAIL busy_start_done: Done=%b Busy=%b Fword=%0d, required 1 0 1300", sw.Done, sw.Busy, sw.Fword);
        end
        @(negedge clk);
    endtask

    task automatic test_step_zero();
        kick(5, 9, 0, 1, 0);
        n_cmp++; if (sw.Fword !== 32'd5) begin n_err++; $display("FAIL step0_first: Fword=%0d, required 5", sw.Fword); end
        @(negedge clk);
        n_cmp++;
        if (sw.Fword !== 32'd9 || sw.Busy !== 1'b1) begin
            n_err++; $display("FAIL step0_second: Fword=%0d Busy=%b, required 9 1", sw.Fword, sw.Busy);
        end
        @(negedge clk);
        n_cmp++;
        if (sw.Done !== 1'b1 || sw.Fword !== 32'd9) begin
            n_err++; $display("FAIL step0_done: Done=%b Fword=%0d, required 1 9", sw.Done, sw.Fword);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        kick(1, 2, 1, 1, 0);
        n_cmp++; if (sw.Fword !== 32'd1) begin n_err++; $display("FAIL b2b_a0: Fword=%0d, required 1", sw.Fword); end
        @(negedge clk);
        n_cmp++; if (sw.Fword !== 32'd2) begin n_err++; $display("FAIL b2b_a1: Fword=%0d, required 2", sw.Fword); end
        @(negedge clk);
        n_cmp++; if (sw.Done !== 1'b1) begin n_err++; $display("FAIL b2b_a_done: Done=%b, required 1", sw.Done); end
        kick(7, 7, 3, 2, 0);
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (sw.Fword !== 32'd7 || sw.Busy !== 1'b1 || sw.Done !== 1'b0) begin
                n_err++; $display("FAIL b2b_b c%0d: Fword=%0d Busy=%b Done=%b, required 7 1 0", j, sw.Fword, sw.Busy, sw.Done);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (sw.Done !== 1'b1 || sw.Busy !== 1'b0 || sw.Fword !== 32'd7) begin
            n_err++; $display("FAIL b2b_b_done: Done=%b Busy=%b Fword=%0d, required 1 0 7", sw.Done, sw.Busy, sw.Fword);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        kick(40, 80, 20, 5, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (sw.Fword !== 32'd0 || sw.Busy !== 1'b0 || sw.Done !== 1'b0) begin
            n_err++; $display("FAIL reset_mid: Fword=%0d Busy=%b Done=%b, required 0 0 0", sw.Fword, sw.Busy, sw.Done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sw.Busy !== 1'b0 || sw.Fword !== 32'd0) begin
            n_err++; $display("FAIL reset_mid_after: Busy=%b Fword=%0d, required 0 0", sw.Busy, sw.Fword);
        end
    endtask

    initial begin
        test_reset();
        test_up_single();
        test_clamp();
        test_down_dwell0();
        test_continuous_abort();
        test_abort_start_same();
        test_start_while_busy();
        test_step_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
